// File: rtl/adder_scoreboard_if.sv
// adder_scoreboard_if: shared stimulus, DUT outputs and reference outputs observed by the scoreboard
interface adder_scoreboard_if;
   logic in1, in2, cin;
   logic sum, cout;
   logic sumr, coutr;
   modport master (output in1, in2, cin, sum, cout, sumr, coutr);
   modport slave  (input  in1, in2, cin, sum, cout, sumr, coutr);
endinterface

// File: rtl/adder_scoreboard.sv
// adder_scoreboard: checks a 1-bit full adder against its reference and arithmetic,
// counting checks/errors, tracking input coverage and latching the first failure
module adder_scoreboard #(
   parameter int SETTLE_CYCLES = 2,
   parameter int NUM_CHECKS    = 64,
   parameter int CNT_W         = 16
) (
   input  logic               clk,
   input  logic               resetb,
   adder_scoreboard_if.slave  bus,
   output logic               done,
   output logic               pass,
   output logic [CNT_W-1:0]   chk_cnt,
   output logic [CNT_W-1:0]   err_cnt,
   output logic [7:0]         cov,
   output logic               ref_bad,
   output logic [4:0]         first_err_vec,
   output logic [CNT_W-1:0]   first_err_idx
);
   typedef enum logic [1:0] {IDLE, SETTLE, RUN, DONE} state_t;
   state_t state, nxt;
   logic [CNT_W-1:0] scnt, chk_n, err_n;
   logic [7:0] cov_n;
   logic [1:0] exp_sum;
   logic [2:0] vec;
   logic dut_bad, ref_mis, ref_n;
   always_ff @(posedge clk or negedge resetb)
      if (!resetb) state <= IDLE;
      else state <= nxt;
   // case-inequality so X/Z on the DUT outputs is reported as a mismatch
   always_comb begin
      vec     = {bus.in1, bus.in2, bus.cin};
      exp_sum = 2'(bus.in1) + 2'(bus.in2) + 2'(bus.cin);
      dut_bad = ({bus.cout, bus.sum} !== {bus.coutr, bus.sumr}) || ({bus.cout, bus.sum} !== exp_sum);
      ref_mis = {bus.coutr, bus.sumr} !== exp_sum;
      chk_n   = chk_cnt + 1'b1;
      err_n   = err_cnt + CNT_W'(dut_bad);
      cov_n   = ((^vec) !== 1'bx) ? cov | (8'd1 << vec) : cov;
      ref_n   = ref_bad | ref_mis;
      nxt     = state;
      case (state)
         IDLE:    nxt = (SETTLE_CYCLES == 0) ? RUN : SETTLE;
         SETTLE:  nxt = (scnt == CNT_W'(SETTLE_CYCLES - 1)) ? RUN : SETTLE;
         RUN:     nxt = (chk_n == CNT_W'(NUM_CHECKS)) ? DONE : RUN;
         default: nxt = DONE;
      endcase
   end
   always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
         scnt          <= '0;
         chk_cnt       <= '0;
         err_cnt       <= '0;
         cov           <= '0;
         ref_bad       <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         first_err_vec <= '0;
         first_err_idx <= '0;
      end else begin
         scnt <= (state == SETTLE) ? scnt + 1'b1 : '0;
         if (state == RUN) begin
            chk_cnt <= chk_n;
            err_cnt <= err_n;
            cov     <= cov_n;
            ref_bad <= ref_n;
            if (dut_bad && err_cnt == '0) begin
               first_err_vec <= {vec, bus.sum, bus.cout};
               first_err_idx <= chk_cnt;
            end
            if (nxt == DONE) begin
               done <= 1'b1;
               pass <= (err_n == '0) && (cov_n == 8'hFF) && !ref_n;
            end
         end
      end
   end
endmodule

// File: tb/tb_adder_scoreboard.sv
// tb_adder_scoreboard: scenario tasks drive stimulus, push expected snapshots to a queue
// and compare them against the scoreboard outputs one edge later
module tb_adder_scoreboard;
   localparam int S = 2;
   localparam int N = 64;
   localparam int W = 16;
   logic clk = 1'b0;
   logic resetb = 1'b1;
   logic done, pass, ref_bad;
   logic [W-1:0] chk_cnt, err_cnt, first_err_idx;
   logic [7:0] cov;
   logic [4:0] first_err_vec;
   int n_vec = 0;
   int n_bad = 0;
   typedef struct {
      logic [W-1:0] chk;
      logic [W-1:0] err;
      logic [7:0]   cov;
      logic         done;
   } exp_t;
   exp_t sb[$];
   logic [W-1:0] m_chk, m_err, m_idx;
   logic [7:0] m_cov;
   logic m_ref;
   logic [4:0] m_vec;
   adder_scoreboard_if bus();
   adder_scoreboard #(.SETTLE_CYCLES(S), .NUM_CHECKS(N), .CNT_W(W)) dut (
      .clk(clk), .resetb(resetb), .bus(bus),
      .done(done), .pass(pass), .chk_cnt(chk_cnt), .err_cnt(err_cnt), .cov(cov),
      .ref_bad(ref_bad), .first_err_vec(first_err_vec), .first_err_idx(first_err_idx)
   );
   always #5 clk = ~clk;
   task automatic idle_bus;
      bus.in1 = 0; bus.in2 = 0; bus.cin = 0; bus.sum = 0; bus.cout = 0; bus.sumr = 0; bus.coutr = 0;
   endtask
   task automatic apply_reset;
      idle_bus();
      #3 resetb = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) resetb = 1'b1;
   endtask
   // drives sample i for the given mode and advances the bench model
   task automatic drive(input int mode, input int i);
      logic [2:0] v;
      logic [1:0] e;
      logic s, co, sr, cr, bad, rm;
      v  = (mode == 2) ? {1'b0, 2'(i)} : 3'(i);
      e  = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      s  = e[0]; co = e[1]; sr = e[0]; cr = e[1];
      if (mode == 1) s = 1'b0;
      if (mode == 3) cr = 1'b1;
      if (mode == 4 && i == 10) s = 1'bx;
      bus.in1 = v[2]; bus.in2 = v[1]; bus.cin = v[0];
      bus.sum = s; bus.cout = co; bus.sumr = sr; bus.coutr = cr;
      bad = ({co, s} !== {cr, sr}) || ({co, s} !== e);
      rm  = {cr, sr} !== e;
      if (bad && m_err == 0) begin m_vec = {v, s, co}; m_idx = m_chk; end
      m_err = m_err + W'(bad);
      m_chk = m_chk + 1;
      m_cov = m_cov | (8'd1 << v);
      m_ref = m_ref | rm;
      sb.push_back('{chk: m_chk, err: m_err, cov: m_cov, done: (i == N - 1)});
   endtask
   // assumes resetb was just released on a falling edge
   task automatic run_body(input int mode, input string tag);
      exp_t x;
      m_chk = 0; m_err = 0; m_idx = 0; m_cov = 0; m_ref = 0; m_vec = 0;
      sb.delete();
      repeat (1 + S) @(posedge clk);
      #1;
      n_vec++;
      if (done !== 1'b0 || chk_cnt !== 0) begin
         n_bad++;
         $display("FAIL %s settle: done=%b chk_cnt=%0d want 0/0", tag, done, chk_cnt);
      end
      for (int i = 0; i < N; i++) begin
         drive(mode, i);
         @(posedge clk);
         #1;
         x = sb.pop_front();
         n_vec++;
         if (chk_cnt !== x.chk || err_cnt !== x.err || cov !== x.cov || done !== x.done) begin
            n_bad++;
            $display("FAIL %s sample %0d: chk=%0d err=%0d cov=%h done=%b want %0d %0d %h %b",
                     tag, i, chk_cnt, err_cnt, cov, done, x.chk, x.err, x.cov, x.done);
         end
      end
      bus.in1 = 1; bus.in2 = 1; bus.cin = 1; bus.sum = 0; bus.cout = 0; bus.sumr = 0; bus.coutr = 0;
      repeat (3) @(posedge clk);
      #1;
      n_vec++;
      if (chk_cnt !== m_chk || err_cnt !== m_err || done !== 1'b1 || ref_bad !== m_ref) begin
         n_bad++;
         $display("FAIL %s frozen: chk=%0d err=%0d done=%b ref_bad=%b want %0d %0d 1 %b",
                  tag, chk_cnt, err_cnt, done, ref_bad, m_chk, m_err, m_ref);
      end
      n_vec++;
      if (pass !== (m_err == 0 && m_cov == 8'hFF && !m_ref)) begin
         n_bad++;
         $display("FAIL %s pass: got %b", tag, pass);
      end
      n_vec++;
      if (first_err_vec !== m_vec || first_err_idx !== m_idx) begin
         n_bad++;
         $display("FAIL %s first_err: vec=%b idx=%0d want %b %0d", tag, first_err_vec, first_err_idx, m_vec, m_idx);
      end
   endtask
   task automatic test_reset;
      idle_bus();
      #3 resetb = 1'b0;
      #1;
      n_vec++;
      if ({done, pass, chk_cnt, err_cnt, cov, ref_bad, first_err_vec, first_err_idx} !== '0) begin
         n_bad++;
         $display("FAIL reset: outputs not cleared, done=%b chk_cnt=%0d", done, chk_cnt);
      end
      repeat (2) @(posedge clk);
      @(negedge clk) resetb = 1'b1;
   endtask
   task automatic test_all_combos;
      apply_reset();
      run_body(0, "all_combos");
      n_vec++;
      if (pass !== 1'b1 || cov !== 8'hFF || err_cnt !== 0 || chk_cnt !== 16'(N)) begin
         n_bad++;
         $display("FAIL all_combos final: pass=%b cov=%h err=%0d chk=%0d want 1 ff 0 %0d", pass, cov, err_cnt, chk_cnt, N);
      end
   endtask
   task automatic test_sum_stuck0;
      apply_reset();
      run_body(1, "sum_stuck0");
      n_vec++;
      if (err_cnt !== 32 || first_err_vec !== 5'b00100 || first_err_idx !== 1 || pass !== 1'b0) begin
         n_bad++;
         $display("FAIL sum_stuck0 final: err=%0d vec=%b idx=%0d pass=%b want 32 00100 1 0",
                  err_cnt, first_err_vec, first_err_idx, pass);
      end
   endtask
   task automatic test_partial_cov;
      apply_reset();
      run_body(2, "partial_cov");
      n_vec++;
      if (cov !== 8'h0F || err_cnt !== 0 || pass !== 1'b0) begin
         n_bad++;
         $display("FAIL partial_cov final: cov=%h err=%0d pass=%b want 0f 0 0", cov, err_cnt, pass);
      end
   endtask
   task automatic test_ref_bad;
      apply_reset();
      run_body(3, "ref_bad");
      n_vec++;
      if (ref_bad !== 1'b1 || err_cnt !== 32 || pass !== 1'b0) begin
         n_bad++;
         $display("FAIL ref_bad final: ref_bad=%b err=%0d pass=%b want 1 32 0", ref_bad, err_cnt, pass);
      end
   endtask
   task automatic test_sum_x;
      apply_reset();
      run_body(4, "sum_x");
   endtask
   task automatic test_reset_mid_run;
      apply_reset();
      repeat (1 + S) @(posedge clk);
      #1;
      for (int i = 0; i < 27; i++) begin
         bus.in1 = 1'(i >> 2); bus.in2 = 1'(i >> 1); bus.cin = 1'(i);
         {bus.cout, bus.sum} = 2'(bus.in1) + 2'(bus.in2) + 2'(bus.cin);
         {bus.coutr, bus.sumr} = {bus.cout, bus.sum};
         @(posedge clk);
         #1;
      end
      #1 resetb = 1'b0;
      #1;
      n_vec++;
      if ({done, pass, chk_cnt, err_cnt, cov, ref_bad, first_err_vec, first_err_idx} !== '0) begin
         n_bad++;
         $display("FAIL mid_reset: not cleared asynchronously, chk_cnt=%0d cov=%h", chk_cnt, cov);
      end
      repeat (3) @(posedge clk);
      @(negedge clk) resetb = 1'b1;
      run_body(0, "after_reset");
      n_vec++;
      if (chk_cnt !== 16'(N) || pass !== 1'b1) begin
         n_bad++;
         $display("FAIL after_reset final: chk=%0d pass=%b want %0d 1", chk_cnt, pass, N);
      end
   endtask
   initial begin
      test_reset();
      test_all_combos();
      test_sum_stuck0();
      test_partial_cov();
      test_ref_bad();
      test_sum_x();
      test_reset_mid_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
